fetch_pc_unit: RTL and testbench

//  Instruction-fetch stage that feeds the control unit and datapath. Holds the PC, requests

---
 rtl/fetch_pc_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake with a bounded wait,
// holds the fetched word until retire, then forms the sequential, branch or jump successor.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             retire,
    input  logic             PCSrc,
    input  logic             Jump,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_err,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t             state_r,       state_nxt_s;
    logic [31:0]        pc_r,          pc_nxt_s;
    logic               imem_req_r,    imem_req_nxt_s;
    logic [31:0]        instr_r,       instr_nxt_s;
    logic               instr_valid_r, instr_valid_nxt_s;
    logic               fetch_err_r,   fetch_err_nxt_s;
    logic [CNT_W-1:0]   retired_cnt_r, retired_cnt_nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r,    wait_cnt_nxt_s;

    logic [31:0]        pc_plus4_s;
    logic [31:0]        jump_target_s;
    logic [31:0]        branch_target_s;
    logic [WAIT_W-1:0]  wait_inc_s;

    assign pc_plus4_s      = pc_r + 32'd4;
    assign jump_target_s   = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
    assign branch_target_s = pc_plus4_s + {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
    assign wait_inc_s      = wait_cnt_r + WAIT_W'(1);

    // Next-state and next-register logic for the fetch sequencer
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        imem_req_nxt_s    = imem_req_r;
        instr_nxt_s       = instr_r;
        instr_valid_nxt_s = instr_valid_r;
        fetch_err_nxt_s   = fetch_err_r;
        retired_cnt_nxt_s = retired_cnt_r;
        wait_cnt_nxt_s    = wait_cnt_r;

        case (state_r)
            ST_IDLE: begin
                state_nxt_s    = ST_FETCH;
                imem_req_nxt_s = 1'b1;
            end
            ST_FETCH: begin
                // An ack arriving on the timeout cycle still completes the fetch
                if (imem_ack) begin
                    instr_nxt_s       = imem_rdata;
                    instr_valid_nxt_s = 1'b1;
                    imem_req_nxt_s    = 1'b0;
                    wait_cnt_nxt_s    = {WAIT_W{1'b0}};
                    state_nxt_s       = ST_EXEC;
                end else if (wait_inc_s == WAIT_W'(MAX_WAIT)) begin
                    imem_req_nxt_s    = 1'b0;
                    fetch_err_nxt_s   = 1'b1;
                    wait_cnt_nxt_s    = wait_inc_s;
                    state_nxt_s       = ST_HALT;
                end else begin
                    wait_cnt_nxt_s    = wait_inc_s;
                end
            end
            ST_EXEC: begin
                if (retire) begin
                    if (Jump) begin
                        pc_nxt_s = jump_target_s;
                    end else if (PCSrc) begin
                        pc_nxt_s = branch_target_s;
                    end else begin
                        pc_nxt_s = pc_plus4_s;
                    end
                    instr_valid_nxt_s = 1'b0;
                    retired_cnt_nxt_s = retired_cnt_r + CNT_W'(1);
                    imem_req_nxt_s    = 1'b1;
                    state_nxt_s       = ST_FETCH;
                end else begin
                    state_nxt_s       = ST_EXEC;
                end
            end
            ST_HALT: begin
                imem_req_nxt_s    = 1'b0;
                instr_valid_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s       = ST_IDLE;
                imem_req_nxt_s    = 1'b0;
                instr_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            imem_req_r    <= 1'b0;
            instr_r       <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            fetch_err_r   <= 1'b0;
            retired_cnt_r <= {CNT_W{1'b0}};
            wait_cnt_r    <= {WAIT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            imem_req_r    <= imem_req_nxt_s;
            instr_r       <= instr_nxt_s;
            instr_valid_r <= instr_valid_nxt_s;
            fetch_err_r   <= fetch_err_nxt_s;
            retired_cnt_r <= retired_cnt_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign fetch_err   = fetch_err_r;
    assign retired_cnt = retired_cnt_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: fetched words and successor PCs are queued when driven
// and compared when the unit presents them.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 4;
    localparam int          CNT_W    = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic [31:0]      instr;
    logic             instr_valid;
    logic             retire;
    logic             PCSrc;
    logic             Jump;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             fetch_err;
    logic [CNT_W-1:0] retired_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] sb_instr[$];
    logic [31:0] sb_pc[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;

    fetch_pc_unit #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .retire      (retire),
        .PCSrc       (PCSrc),
        .Jump        (Jump),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Successor PC written from the architectural definition
    function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [31:0] ins,
                                            input logic src, input logic jmp);
        logic [31:0] seq;
        logic signed [31:0] off;
        seq = cur + 32'd4;
        off = 32'($signed(ins[15:0])) * 32'sd4;
        if (jmp)
            return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
        else if (src)
            return seq + 32'(off);
        else
            return seq;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0;
        retire = 1'b0;
        step();
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rst_err", {31'b0, fetch_err}, 32'd0);
        check_eq("rst_cnt", retired_cnt, 32'd0);
        reset = 1'b0;
        sb_instr.delete();
        sb_pc.delete();
        m_pc = RESET_PC;
        m_cnt = 32'd0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 8) begin
            step();
            n++;
        end
        check_eq("req_wait", {31'b0, imem_req}, 32'd1);
    endtask

    // ack arrives in the lat-th FETCH cycle
    task automatic do_fetch(input int lat, input logic [31:0] data);
        logic [31:0] exp;
        wait_req();
        check_eq("fetch_addr", imem_addr, m_pc);
        sb_instr.push_back(data);
        for (int i = 1; i < lat; i++) begin
            step();
            check_eq("addr_stable", imem_addr, m_pc);
            check_eq("req_held", {31'b0, imem_req}, 32'd1);
            check_eq("valid_low", {31'b0, instr_valid}, 32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        step();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        check_eq("valid_rise", {31'b0, instr_valid}, 32'd1);
        check_eq("req_drop", {31'b0, imem_req}, 32'd0);
        if (sb_instr.size() > 0) begin
            exp = sb_instr.pop_front();
            check_eq("instr", instr, exp);
            m_instr = exp;
        end
    endtask

    task automatic do_retire(input logic src, input logic jmp);
        logic [31:0] exp;
        sb_pc.push_back(next_pc(m_pc, m_instr, src, jmp));
        m_cnt = m_cnt + 32'd1;
        retire = 1'b1;
        PCSrc = src;
        Jump = jmp;
        step();
        retire = 1'b0;
        PCSrc = 1'b0;
        Jump = 1'b0;
        exp = sb_pc.pop_front();
        check_eq("next_pc", pc, exp);
        check_eq("pc_plus4", pc_plus4, exp + 32'd4);
        check_eq("ret_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("ret_req", {31'b0, imem_req}, 32'd1);
        check_eq("ret_cnt", retired_cnt, m_cnt);
        m_pc = exp;
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        retire = 1'b0;
        PCSrc = 1'b0;
        Jump = 1'b0;
        m_instr = 32'h0;
        step();
        do_reset();

        // sequential fetches with zero-wait ack
        do_fetch(1, 32'h2008_0001);
        do_retire(1'b0, 1'b0);
        do_fetch(1, 32'h2008_0002);
        do_retire(1'b0, 1'b0);
        do_fetch(1, 32'h2008_0003);
        do_retire(1'b0, 1'b0);
        check_eq("pc_0xc", pc, 32'h0000_000C);
        check_eq("cnt_3", retired_cnt, 32'd3);

        // jump to 0x100, then negative branch with 3-cycle ack latency
        do_fetch(2, 32'h0800_0040);
        do_retire(1'b0, 1'b1);
        do_fetch(3, 32'h1000_FFFE);
        do_retire(1'b1, 1'b0);
        check_eq("branch_neg", pc, 32'h0000_00FC);

        // ack on the timeout boundary, then jump beats branch
        do_fetch(MAX_WAIT, 32'h0810_0000);
        do_retire(1'b0, 1'b1);
        check_eq("jump_far", pc, 32'h0040_0000);
        do_fetch(2, 32'h0810_0010);
        do_retire(1'b1, 1'b1);
        check_eq("jump_wins", pc, 32'h0040_0040);

        // retire during FETCH is ignored
        retire = 1'b1;
        step();
        retire = 1'b0;
        check_eq("early_ret_pc", pc, m_pc);
        check_eq("early_ret_cnt", retired_cnt, m_cnt);
        do_fetch(1, 32'h2000_0000);

        // reset from EXEC, then wrap through 0xFFFF_FFFC
        do_reset();
        do_fetch(1, 32'h1000_FFFE);
        do_retire(1'b1, 1'b0);
        check_eq("pc_top", pc, 32'hFFFF_FFFC);
        do_fetch(1, 32'h2000_0000);
        do_retire(1'b0, 1'b0);
        check_eq("pc_wrap", pc, 32'h0000_0000);

        // reset from FETCH, then timeout into HALT
        do_reset();
        wait_req();
        for (int i = 1; i < MAX_WAIT; i++) begin
            step();
            check_eq("to_err_low", {31'b0, fetch_err}, 32'd0);
            check_eq("to_req_high", {31'b0, imem_req}, 32'd1);
        end
        step();
        check_eq("to_err", {31'b0, fetch_err}, 32'd1);
        check_eq("to_req", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        retire = 1'b1;
        Jump = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        retire = 1'b0;
        Jump = 1'b0;
        check_eq("halt_pc", pc, RESET_PC);
        check_eq("halt_err", {31'b0, fetch_err}, 32'd1);
        check_eq("halt_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("halt_req", {31'b0, imem_req}, 32'd0);
        check_eq("halt_cnt", retired_cnt, 32'd0);

        // recovery after reset
        do_reset();
        do_fetch(1, 32'h2000_0005);
        do_retire(1'b0, 1'b0);
        check_eq("recover_pc", pc, 32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
